// File: rtl/serdes_reset_ctrl.sv
// serdes_reset_ctrl
//   Reset sequencer for a multi-channel transceiver sharing one TX PLL.
//   A shared TX machine powers the PLL up and releases the per-channel TX resets
//   once lock is stable. An independent RX machine per channel walks
//   analog reset -> lock-to-data wait -> ready, recovering on lock loss,
//   lock timeout or a software request.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   pll_locked            TX PLL lock (async)
//   pll_cal_busy          PLL calibration busy (async)
//   tx_cal_busy[ch]       TX calibration busy (async)
//   rx_cal_busy[ch]       RX calibration busy (async)
//   rx_is_lockedtodata    CDR locked to data (async)
//   rx_reset_req[ch]      one-cycle RX restart request (synchronous)
//   pll_powerdown         PLL powerdown
//   tx_analogreset, tx_digitalreset, tx_ready        per-channel TX controls
//   rx_analogreset, rx_digitalreset, rx_ready        per-channel RX controls
//   rx_timeout[ch]        one-cycle pulse when lock-to-data wait times out
module serdes_reset_ctrl #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned T_PLL_PD    = 100,
    parameter int unsigned T_TX_DIG    = 200,
    parameter int unsigned T_RX_ANA    = 100,
    parameter int unsigned T_LTD       = 400,
    parameter int unsigned LTD_TIMEOUT = 100000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pll_locked,
    input  logic              pll_cal_busy,
    input  logic [NUM_CH-1:0] tx_cal_busy,
    input  logic [NUM_CH-1:0] rx_cal_busy,
    input  logic [NUM_CH-1:0] rx_is_lockedtodata,
    input  logic [NUM_CH-1:0] rx_reset_req,
    output logic              pll_powerdown,
    output logic [NUM_CH-1:0] tx_analogreset,
    output logic [NUM_CH-1:0] tx_digitalreset,
    output logic [NUM_CH-1:0] tx_ready,
    output logic [NUM_CH-1:0] rx_analogreset,
    output logic [NUM_CH-1:0] rx_digitalreset,
    output logic [NUM_CH-1:0] rx_ready,
    output logic [NUM_CH-1:0] rx_timeout
);

    localparam int unsigned MAX_1 = (T_PLL_PD > T_TX_DIG) ? T_PLL_PD : T_TX_DIG;
    localparam int unsigned MAX_2 = (MAX_1 > T_RX_ANA) ? MAX_1 : T_RX_ANA;
    localparam int unsigned MAX_3 = (MAX_2 > T_LTD) ? MAX_2 : T_LTD;
    localparam int unsigned MAX_P = (MAX_3 > LTD_TIMEOUT) ? MAX_3 : LTD_TIMEOUT;
    localparam int unsigned CW    = $clog2(MAX_P) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t PD_LAST  = CW'(T_PLL_PD - 1);
    localparam cnt_t DIG_LAST = CW'(T_TX_DIG - 1);
    localparam cnt_t ANA_LAST = CW'(T_RX_ANA - 1);
    localparam cnt_t LTD_CNT  = CW'(T_LTD);
    localparam cnt_t TMO_LAST = CW'(LTD_TIMEOUT - 1);

    typedef enum logic [1:0] {StPd, StWaitLock, StStable, StTxReady} tx_state_e;
    typedef enum logic [1:0] {StAna, StWaitLtd, StRxReady} rx_state_e;

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == {CW{1'b1}}) ? c : c + cnt_t'(1);
    endfunction

    // ------------------------------------------------------------------
    // Two-flop synchronisers for every asynchronous input
    // ------------------------------------------------------------------
    localparam int unsigned NS = 2 + 3 * NUM_CH;

    logic [NS-1:0] async_in, sync1_q, sync2_q;

    assign async_in = {rx_is_lockedtodata, rx_cal_busy, tx_cal_busy, pll_cal_busy, pll_locked};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
        end
    end

    logic              lock_s, pcal_s;
    logic [NUM_CH-1:0] tcal_s, rcal_s, ltd_s;

    assign lock_s = sync2_q[0];
    assign pcal_s = sync2_q[1];
    assign tcal_s = sync2_q[2 +: NUM_CH];
    assign rcal_s = sync2_q[2 + NUM_CH +: NUM_CH];
    assign ltd_s  = sync2_q[2 + 2 * NUM_CH +: NUM_CH];

    // ------------------------------------------------------------------
    // Shared TX sequencer
    // ------------------------------------------------------------------
    tx_state_e         tx_state_q, tx_state_d;
    cnt_t              tx_cnt_q, tx_cnt_d;
    logic [NUM_CH-1:0] tx_ana_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        case (tx_state_q)
            StPd: begin
                if (tx_cnt_q >= PD_LAST) begin
                    tx_state_d = StWaitLock;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = sat_inc(tx_cnt_q);
                end
            end
            StWaitLock: begin
                tx_cnt_d = '0;
                if (lock_s && !pcal_s) begin
                    tx_state_d = StStable;
                end
            end
            StStable: begin
                if (!lock_s || pcal_s) begin
                    tx_state_d = StWaitLock;
                    tx_cnt_d   = '0;
                end else if (tx_cnt_q >= DIG_LAST) begin
                    tx_state_d = StTxReady;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = sat_inc(tx_cnt_q);
                end
            end
            StTxReady: begin
                tx_cnt_d = '0;
                if (!lock_s) begin
                    tx_state_d = StWaitLock;
                end
            end
            default: begin
                tx_state_d = StPd;
                tx_cnt_d   = '0;
            end
        endcase
    end

    // Analog reset is held through powerdown, then each channel drops it once
    // its calibration is idle; it never re-asserts short of a full reset.
    always_comb begin
        if (tx_state_q == StPd) begin
            tx_ana_d = '1;
        end else begin
            tx_ana_d = tx_analogreset & tcal_s;
        end
    end

    // Outputs are registered from the next state so lock loss shows up
    // on the same edge the machine reacts to it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q      <= StPd;
            tx_cnt_q        <= '0;
            pll_powerdown   <= 1'b1;
            tx_analogreset  <= '1;
            tx_digitalreset <= '1;
            tx_ready        <= '0;
        end else begin
            tx_state_q      <= tx_state_d;
            tx_cnt_q        <= tx_cnt_d;
            pll_powerdown   <= (tx_state_d == StPd);
            tx_analogreset  <= tx_ana_d;
            tx_digitalreset <= (tx_state_d == StTxReady) ? tx_ana_d : '1;
            tx_ready        <= ~tx_digitalreset;
        end
    end

    // ------------------------------------------------------------------
    // Independent RX sequencer per channel
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_rx
        rx_state_e st_q, st_d;
        cnt_t      cnt_q, cnt_d;    // analog hold count, then lock-stable count
        cnt_t      wcnt_q, wcnt_d;  // lock-wait timeout count
        logic      tmo_d;
        logic      ana_q, dig_q, rdy_q, tmo_q;

        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            wcnt_d = wcnt_q;
            tmo_d  = 1'b0;
            if (rx_reset_req[i]) begin
                // Request beats any lock or timeout event of the same cycle.
                st_d   = StAna;
                cnt_d  = '0;
                wcnt_d = '0;
            end else begin
                case (st_q)
                    StAna: begin
                        if (cnt_q >= ANA_LAST && !rcal_s[i]) begin
                            st_d   = StWaitLtd;
                            cnt_d  = '0;
                            wcnt_d = '0;
                        end else begin
                            cnt_d = sat_inc(cnt_q);
                        end
                    end
                    StWaitLtd: begin
                        wcnt_d = sat_inc(wcnt_q);
                        if (ltd_s[i] && cnt_q >= LTD_CNT) begin
                            st_d   = StRxReady;
                            cnt_d  = '0;
                            wcnt_d = '0;
                        end else if (wcnt_q >= TMO_LAST) begin
                            tmo_d  = 1'b1;
                            st_d   = StAna;
                            cnt_d  = '0;
                            wcnt_d = '0;
                        end else if (ltd_s[i]) begin
                            cnt_d = sat_inc(cnt_q);
                        end else begin
                            cnt_d = '0;
                        end
                    end
                    StRxReady: begin
                        if (!ltd_s[i]) begin
                            st_d   = StWaitLtd;
                            cnt_d  = '0;
                            wcnt_d = '0;
                        end
                    end
                    default: begin
                        st_d   = StAna;
                        cnt_d  = '0;
                        wcnt_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                st_q   <= StAna;
                cnt_q  <= '0;
                wcnt_q <= '0;
                ana_q  <= 1'b1;
                dig_q  <= 1'b1;
                rdy_q  <= 1'b0;
                tmo_q  <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                wcnt_q <= wcnt_d;
                ana_q  <= (st_d == StAna);
                dig_q  <= (st_d != StRxReady);
                rdy_q  <= (st_d == StRxReady);
                tmo_q  <= tmo_d;
            end
        end

        assign rx_analogreset[i]  = ana_q;
        assign rx_digitalreset[i] = dig_q;
        assign rx_ready[i]        = rdy_q;
        assign rx_timeout[i]      = tmo_q;
    end

endmodule

// File: tb/tb_serdes_reset_ctrl.sv
// Self-checking bench for serdes_reset_ctrl. A timestamp/run-length reference
// model predicts every output after every clock edge; directed spot checks
// cover the documented timing points.
module tb_serdes_reset_ctrl;

    localparam int NC  = 4;
    localparam int TPD = 10;
    localparam int TTX = 20;
    localparam int TRA = 8;
    localparam int TLT = 16;
    localparam int TMO = 100;

    localparam int M_ANA  = 0;
    localparam int M_WAIT = 1;
    localparam int M_UP   = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          pll_locked, pll_cal_busy;
    logic [NC-1:0] tx_cal_busy, rx_cal_busy, ltd, req;
    logic          pll_powerdown;
    logic [NC-1:0] tx_analogreset, tx_digitalreset, tx_ready;
    logic [NC-1:0] rx_analogreset, rx_digitalreset, rx_ready, rx_timeout;

    serdes_reset_ctrl #(
        .NUM_CH      (NC),
        .T_PLL_PD    (TPD),
        .T_TX_DIG    (TTX),
        .T_RX_ANA    (TRA),
        .T_LTD       (TLT),
        .LTD_TIMEOUT (TMO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .pll_locked         (pll_locked),
        .pll_cal_busy       (pll_cal_busy),
        .tx_cal_busy        (tx_cal_busy),
        .rx_cal_busy        (rx_cal_busy),
        .rx_is_lockedtodata (ltd),
        .rx_reset_req       (req),
        .pll_powerdown      (pll_powerdown),
        .tx_analogreset     (tx_analogreset),
        .tx_digitalreset    (tx_digitalreset),
        .tx_ready           (tx_ready),
        .rx_analogreset     (rx_analogreset),
        .rx_digitalreset    (rx_digitalreset),
        .rx_ready           (rx_ready),
        .rx_timeout         (rx_timeout)
    );

    always #5 clock = ~clock;

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            k;          // edge index since reset release
    bit            tx_up;      // TX channels allowed out of digital reset
    int            run;        // consecutive edges with lock and no PLL cal
    logic          m_pd;
    logic [NC-1:0] m_txana, m_txdig, m_txrdy;
    logic          h1_lk, h2_lk, h1_pc, h2_pc;
    logic [NC-1:0] h1_tc, h2_tc, h1_rc, h2_rc, h1_lt, h2_lt;
    int            mode   [NC];
    int            ana_t  [NC];  // edge analog reset last started
    int            wait_t [NC];  // edge lock wait last started
    int            low_t  [NC];  // last edge the synchronised lock was low
    logic [NC-1:0] m_rxana, m_rxdig, m_rxrdy, m_tmo;

    task automatic model_reset();
        k       = 0;
        tx_up   = 0;
        run     = 0;
        m_pd    = 1'b1;
        m_txana = '1;
        m_txdig = '1;
        m_txrdy = '0;
        h1_lk = 0; h2_lk = 0; h1_pc = 0; h2_pc = 0;
        h1_tc = '0; h2_tc = '0; h1_rc = '0; h2_rc = '0; h1_lt = '0; h2_lt = '0;
        for (int i = 0; i < NC; i++) begin
            mode[i]   = M_ANA;
            ana_t[i]  = -1;
            wait_t[i] = 0;
            low_t[i]  = -1;
        end
        m_rxana = '1;
        m_rxdig = '1;
        m_rxrdy = '0;
        m_tmo   = '0;
    endtask

    task automatic model_step(input logic lk, input logic pc, input logic [NC-1:0] tc,
                              input logic [NC-1:0] rc, input logic [NC-1:0] lt,
                              input logic [NC-1:0] rq);
        logic          lk_s, pc_s, ok;
        logic [NC-1:0] tc_s, rc_s, lt_s;
        int            from;
        lk_s = h2_lk; pc_s = h2_pc; tc_s = h2_tc; rc_s = h2_rc; lt_s = h2_lt;
        ok   = lk_s && !pc_s;

        if (k >= TPD) begin
            if (tx_up) begin
                if (!lk_s) begin
                    tx_up = 0;
                    run   = 0;
                end
            end else begin
                run = ok ? run + 1 : 0;
                if (run >= TTX + 1) tx_up = 1;
            end
            m_txana = m_txana & tc_s;
        end
        m_pd    = (k < TPD - 1);
        m_txrdy = ~m_txdig;
        m_txdig = tx_up ? m_txana : '1;

        for (int i = 0; i < NC; i++) begin
            m_tmo[i] = 1'b0;
            if (!lt_s[i]) low_t[i] = k;
            if (rq[i]) begin
                mode[i]  = M_ANA;
                ana_t[i] = k;
            end else if (mode[i] == M_ANA) begin
                if (k - ana_t[i] >= TRA && !rc_s[i]) begin
                    mode[i]   = M_WAIT;
                    wait_t[i] = k;
                end
            end else if (mode[i] == M_WAIT) begin
                from = (wait_t[i] > low_t[i]) ? wait_t[i] : low_t[i];
                if (lt_s[i] && (k - from) >= TLT + 1) begin
                    mode[i] = M_UP;
                end else if (k - wait_t[i] >= TMO) begin
                    m_tmo[i] = 1'b1;
                    mode[i]  = M_ANA;
                    ana_t[i] = k;
                end
            end else begin
                if (!lt_s[i]) begin
                    mode[i]   = M_WAIT;
                    wait_t[i] = k;
                end
            end
            m_rxana[i] = (mode[i] == M_ANA);
            m_rxdig[i] = (mode[i] != M_UP);
            m_rxrdy[i] = (mode[i] == M_UP);
        end

        h2_lk = h1_lk; h1_lk = lk;
        h2_pc = h1_pc; h1_pc = pc;
        h2_tc = h1_tc; h1_tc = tc;
        h2_rc = h1_rc; h1_rc = rc;
        h2_lt = h1_lt; h1_lt = lt;
        k++;
    endtask

    task automatic compare_all();
        check_eq("pll_powerdown", pll_powerdown, m_pd);
        check_eq("tx_analogreset", tx_analogreset, m_txana);
        check_eq("tx_digitalreset", tx_digitalreset, m_txdig);
        check_eq("tx_ready", tx_ready, m_txrdy);
        check_eq("rx_analogreset", rx_analogreset, m_rxana);
        check_eq("rx_digitalreset", rx_digitalreset, m_rxdig);
        check_eq("rx_ready", rx_ready, m_rxrdy);
        check_eq("rx_timeout", rx_timeout, m_tmo);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pll_powerdown"}, pll_powerdown, 1);
        check_eq({tag, "_tx_analogreset"}, tx_analogreset, 4'hF);
        check_eq({tag, "_tx_digitalreset"}, tx_digitalreset, 4'hF);
        check_eq({tag, "_tx_ready"}, tx_ready, 0);
        check_eq({tag, "_rx_analogreset"}, rx_analogreset, 4'hF);
        check_eq({tag, "_rx_digitalreset"}, rx_digitalreset, 4'hF);
        check_eq({tag, "_rx_ready"}, rx_ready, 0);
        check_eq({tag, "_rx_timeout"}, rx_timeout, 0);
    endtask

    // Called just after a negedge; returns at the following negedge.
    task automatic tick();
        logic          lk, pc;
        logic [NC-1:0] tc, rc, lt, rq;
        @(posedge clock);
        lk = pll_locked; pc = pll_cal_busy; tc = tx_cal_busy;
        rc = rx_cal_busy; lt = ltd; rq = req;
        #1;
        model_step(lk, pc, tc, rc, lt, rq);
        compare_all();
        @(negedge clock);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
    endtask

    int pd_high;
    int tmo_cnt;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        pll_locked   = 1'b0;
        pll_cal_busy = 1'b0;
        tx_cal_busy  = '0;
        rx_cal_busy  = '0;
        ltd          = '0;
        req          = '0;
        model_reset();

        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("reset");

        // ---- directed scenario ----
        release_reset();
        pd_high = pll_powerdown ? 1 : 0;
        tmo_cnt = 0;
        for (int c = 0; c < 800; c++) begin
            pll_locked   = (c >= 30);
            pll_cal_busy = 1'b0;
            tx_cal_busy  = (c < 50) ? 4'b0100 : 4'b0000;
            rx_cal_busy  = (c < 5) ? 4'hF : 4'h0;
            ltd[0]       = !(c >= 200 && c < 210);
            ltd[1]       = (c < 60) ? ((c / 10) % 2 == 1) : 1'b1;
            ltd[2]       = !(c >= 400 && c < 690);
            ltd[3]       = !(c >= 298 && c < 310);
            req          = (c == 300) ? 4'b1000 : 4'b0000;
            tick();
            if (c < 40 && pll_powerdown) pd_high++;
            if (c == 40) check_eq("pd_high_cycles", pd_high, TPD);
            if (c == 10) check_eq("txana_after_pd", tx_analogreset, 4'b0100);
            if (c == 51) check_eq("txana_ch2_held", tx_analogreset, 4'b0100);
            if (c == 51) check_eq("txdig_before_ready", tx_digitalreset, 4'hF);
            if (c == 52) check_eq("txdig_release", tx_digitalreset, 4'h0);
            if (c == 52) check_eq("txrdy_lag", tx_ready, 4'h0);
            if (c == 53) check_eq("txrdy_up", tx_ready, 4'hF);
            if (c == 67) check_eq("rxrdy1_early", rx_ready[1], 0);
            if (c == 68) check_eq("rxrdy1_up", rx_ready[1], 1);
            if (c == 202) check_eq("rxrdy_ch0_drop", rx_ready, 4'b1110);
            if (c == 300) check_eq("req3_ana", rx_analogreset[3], 1);
            if (c == 300) check_eq("req3_rdy", rx_ready[3], 0);
            if (c >= 400 && c < 700 && rx_timeout[2]) tmo_cnt++;
            if (c == 699) check_eq("timeout_pulses", tmo_cnt, 2);
        end

        // ---- lock glitch, then reset in the middle of the stable count ----
        for (int c = 0; c < 17; c++) begin
            pll_locked = (c >= 5);
            tick();
        end
        check_eq("stable_not_ready", tx_ready, 4'h0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async");
        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("held");
        release_reset();

        // ---- randomised traffic ----
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(149) == 0) pll_locked = ~pll_locked;
            if (pll_cal_busy) begin
                if ($urandom_range(9) == 0) pll_cal_busy = 1'b0;
            end else if ($urandom_range(399) == 0) begin
                pll_cal_busy = 1'b1;
            end
            for (int i = 0; i < NC; i++) begin
                if (tx_cal_busy[i]) begin
                    if ($urandom_range(9) == 0) tx_cal_busy[i] = 1'b0;
                end else if ($urandom_range(199) == 0) begin
                    tx_cal_busy[i] = 1'b1;
                end
                if (rx_cal_busy[i]) begin
                    if ($urandom_range(9) == 0) rx_cal_busy[i] = 1'b0;
                end else if ($urandom_range(199) == 0) begin
                    rx_cal_busy[i] = 1'b1;
                end
                if (ltd[i]) begin
                    if ($urandom_range(299) == 0) ltd[i] = 1'b0;
                end else if ($urandom_range(59) == 0) begin
                    ltd[i] = 1'b1;
                end
                req[i] = ($urandom_range(99) == 0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serdes_reset_ctrl.md
# serdes_reset_ctrl

Parametrised transceiver reset sequencer for the fiber SERDES data-out path, serving NUM_CH channels that share one TX PLL. It powers up the PLL, sequences per-channel TX analog/digital reset on PLL lock and calibration, and runs an independent RX reset state machine per channel. Each RX machine recovers from loss of lock to data, a lock timeout, or a software reset request without disturbing the other channels. The block sits between the fabric clock/reset and the transceiver PHY reset ports.

## Interface
- NUM_CH, 2: number of transceiver channels (1..16)
- T_PLL_PD, 100: pll_powerdown hold, clock cycles
- T_TX_DIG, 200: cycles pll_locked must be stable before tx_digitalreset release
- T_RX_ANA, 100: minimum rx_analogreset hold, cycles
- T_LTD, 400: consecutive rx_is_lockedtodata cycles before rx_digitalreset release
- LTD_TIMEOUT, 100000: cycles in RX lock wait before re-pulsing rx_analogreset

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- pll_locked  in  1  TX PLL lock (async)
- pll_cal_busy  in  1  PLL calibration busy (async)
- tx_cal_busy  in  NUM_CH  TX calibration busy (async)
- rx_cal_busy  in  NUM_CH  RX calibration busy (async)
- rx_is_lockedtodata  in  NUM_CH  CDR locked to data (async)
- rx_reset_req  in  NUM_CH  one-cycle request to restart channel RX sequence (synchronous)
- pll_powerdown  out  1  PLL powerdown
- tx_analogreset / tx_digitalreset  out  NUM_CH  TX resets
- tx_ready  out  NUM_CH  TX channel ready
- rx_analogreset / rx_digitalreset  out  NUM_CH  RX resets
- rx_ready  out  NUM_CH  RX channel ready
- rx_timeout  out  NUM_CH  one-cycle pulse on LTD timeout

## Operation
- All async inputs pass through 2-flop synchronisers; all decisions use synchronised values. All outputs are registered.
- Reset values: pll_powerdown=1, tx_analogreset=all 1, tx_digitalreset=all 1, tx_ready=0, rx_analogreset=all 1, rx_digitalreset=all 1, rx_ready=0, rx_timeout=0. Every FSM enters its first state and every counter clears.
- TX FSM (shared):
  - PD: pll_powerdown=1; count T_PLL_PD cycles, then WAIT_LOCK.
  - WAIT_LOCK: pll_powerdown=0; go to STABLE when pll_locked=1 and pll_cal_busy=0.
  - STABLE: count T_TX_DIG cycles; pll_locked=0 or pll_cal_busy=1 returns to WAIT_LOCK and clears the count; at terminal count go to READY.
  - READY: pll_locked=0 returns to WAIT_LOCK.
- tx_analogreset[i]:
  - Set in PD.
  - Cleared on the first cycle outside PD with tx_cal_busy[i]=0.
  - Once cleared, stays 0 until PD is re-entered (only via reset).
- tx_digitalreset[i]=0 only in READY with tx_analogreset[i]=0; tx_ready[i]=!tx_digitalreset[i], delayed 1 cycle.
- RX FSM per channel i, all channels independent:
  - ANA: rx_analogreset=1, rx_digitalreset=1. Leave to WAIT_LTD after at least T_RX_ANA cycles and rx_cal_busy[i]=0.
  - WAIT_LTD: rx_analogreset=0.
    - Stable counter increments while rx_is_lockedtodata[i]=1 and clears when it is 0.
    - Reaching T_LTD goes to READY.
    - A separate wait counter reaching LTD_TIMEOUT pulses rx_timeout[i] and goes to ANA.
  - READY: rx_digitalreset=0; rx_ready=1. rx_is_lockedtodata[i]=0 goes to WAIT_LTD and clears both counters.
  - rx_reset_req[i]=1 in any state goes to ANA next cycle. It takes priority over the timeout and lock events of the same cycle.
- RX sequencing does not wait on the PLL or the TX FSM.
- Counter width is $clog2 of the largest parameter + 1. Counters saturate and never wrap.

## Timing
- Input-to-decision latency: 2 cycles for synchronisers, plus 1 for the FSM register.
- pll_powerdown is high for exactly T_PLL_PD cycles after reset release.
- TX: after pll_locked rises and pll_cal_busy is low, tx_digitalreset falls 2+T_TX_DIG+1 cycles later (±1 defined by implementation, then fixed); tx_ready follows 1 cycle later.
- pll_locked loss while in READY: tx_digitalreset=1 and tx_ready=0 within 3 cycles (2 sync + 1).
- RX lock loss while in READY: rx_digitalreset=1 and rx_ready=0 within 3 cycles.
- rx_reset_req: rx_analogreset=1 and rx_ready=0 on the cycle after the request.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronously).

## Test plan
- NUM_CH=4, T_PLL_PD=10, T_TX_DIG=20: release reset, raise pll_locked at cycle 30 -> pll_powerdown high for cycles 0–9; tx_digitalreset falls about 23 cycles after lock; tx_ready follows 1 cycle later.
- tx_cal_busy[2] held until cycle 50 -> tx_analogreset[2], tx_digitalreset[2] and tx_ready[2] are delayed; other channels are unaffected.
- T_RX_ANA=8, T_LTD=16: rx_is_lockedtodata[1] toggles every 10 cycles, then held high -> no rx_ready[1] during toggling; rx_ready[1] rises 16+3 cycles after the hold begins.
- Drop rx_is_lockedtodata[0] in READY -> rx_ready[0] low within 3 cycles; channels 1–3 stay ready.
- LTD_TIMEOUT=100 with lock never asserted -> rx_timeout pulses every ~100+T_RX_ANA cycles, with a fresh rx_analogreset pulse each time.
- rx_reset_req[3] in the same cycle as lock loss, and reset asserted mid-STABLE -> channel 3 goes to ANA; async reset restores all reset values immediately.
